mmio_timer: RTL

Memory-mapped 32-bit down-counting timer sitting behind the memory-stage bus bridge, directly downstream of the byte-enable/exception stage. It consumes the word-aligned, exception-free stores that stage releases and returns read data for timer-range loads. Two instances are mapped at 0x0000_7F00 (TC0) and 0x0000_7F10 (TC1). Each raises an interrupt request to the CP0 stage when its count expires.

---
 rtl/mmio_pkg.sv | 31 +++
 rtl/mmio_timer.sv | 104 ++++++++++
 2 files changed

// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped timer: FSM encodings, register
// offsets, CTRL bit positions and instance base addresses. The bridge and the
// exception check import the base addresses from here as well.
package mmio_pkg;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_CNT  = 2'd2;
  localparam logic [1:0] ST_INT  = 2'd3;

  // Register offsets, decoded from addr[3:2]
  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  // CTRL bit positions
  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  // Mode values; anything other than auto-reload behaves as one-shot
  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_AUTO    = 2'b01;

  // Instance base addresses
  localparam logic [31:0] TC0_BASE = 32'h0000_7F00;
  localparam logic [31:0] TC1_BASE = 32'h0000_7F10;

endpackage

// File: rtl/mmio_timer.sv
// 32-bit down-counting MMIO timer. Registers CTRL/PRESET/COUNT live next to
// the four-state FSM that loads, counts and raises the interrupt flag.
module mmio_timer
  import mmio_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  logic [1:0]  state;
  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_flag;

  logic [1:0]  off;
  logic        wr_ctrl;
  logic        wr_preset;
  logic        en;
  logic [1:0]  mode;
  logic        fire;
  logic        in_int;
  logic        addr_unused;

  assign off         = addr[3:2];
  assign addr_unused = ^{addr[31:4], addr[1:0]};
  assign wr_ctrl     = we && (off == ADDR_CTRL);
  assign wr_preset   = we && (off == ADDR_PRESET);
  assign en          = ctrl[CTRL_EN];
  assign mode        = ctrl[CTRL_MODE_HI:CTRL_MODE_LO];

  // Count has run out this cycle: COUNT of 1 or 0 is treated the same, so a
  // PRESET of 0 expires exactly like a PRESET of 1.
  assign fire   = (state == ST_CNT) && en && (count <= 32'd1);
  assign in_int = (state == ST_INT);

  // FSM sequencing and the COUNT register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      count <= '0;
    end else begin
      case (state)
        ST_IDLE: if (en) state <= ST_LOAD;
        ST_LOAD: begin
          count <= preset;
          state <= ST_CNT;
        end
        ST_CNT: begin
          if (!en) begin
            state <= ST_IDLE;
          end else if (fire) begin
            count <= '0;
            state <= ST_INT;
          end else begin
            count <= count - 32'd1;
          end
        end
        ST_INT:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // CPU-visible registers and the interrupt flag; a CTRL write overrides any
  // FSM-driven update to CTRL or the flag in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl     <= '0;
      preset   <= '0;
      irq_flag <= 1'b0;
    end else begin
      if (fire) irq_flag <= 1'b1;
      if (in_int) begin
        if (mode == MODE_AUTO) irq_flag <= 1'b0;
        else                   ctrl[CTRL_EN] <= 1'b0;
      end
      if (wr_ctrl) begin
        ctrl     <= wdata[3:0];
        irq_flag <= 1'b0;
      end
      if (wr_preset) preset <= wdata;
    end
  end

  // Zero-latency read mux
  always_comb begin
    rdata = '0;
    case (off)
      ADDR_CTRL:   rdata = {28'd0, ctrl};
      ADDR_PRESET: rdata = preset;
      ADDR_COUNT:  rdata = count;
      default:     rdata = '0;
    endcase
  end

  assign irq = ctrl[CTRL_IM] & irq_flag;

endmodule
